// File: rtl/nibseq_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and slice width.
// State localparams double as the enum values so the encoding stays pinned.
package nibseq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle; sub exists only when NIBSEQ_SUB_EN is defined.
// master = producer/consumer side, slave = the sequencer.
interface nibble_add_sequencer_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBSEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef NIBSEQ_SUB_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder slice; purely combinational, no handshake.
module nibble_add4
    import nibseq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                cout_o
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit adder running one 4-bit slice over NIB nibbles LSB first; latency NIB+1, one op per NIB+2 cycles.
// Result held in DONE until out_ready; in_ready only in IDLE. NIBSEQ_SUB_EN adds a - b via the sub port.
module nibble_add_sequencer
    import nibseq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_add_sequencer_if.slave  bus
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("WIDTH must be a non-zero multiple of 4");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0]    b_ld;
    logic                c_ld;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;

`ifdef NIBSEQ_SUB_EN
    // Subtraction is a + ~b + 1; the forced carry replaces cin.
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub | bus.cin;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.cin;
`endif

    nibble_add4 u_slice (
        .a_i    (a_q[NIBBLE_W-1:0]),
        .b_i    (b_q[NIBBLE_W-1:0]),
        .cin_i  (carry_q),
        .s_o    (s_nib),
        .cout_o (c_nib)
    );

    // New nibble enters at the top so after NIB steps nibble 0 sits at the LSBs.
    assign sum_d = (sum_q >> NIBBLE_W) | (WIDTH'(s_nib) << (WIDTH - NIBBLE_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= b_ld;
                        carry_q    <= c_ld;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    carry_q <= c_nib;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NIB - 1)) begin
                        cout_q      <= c_nib;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle wide adder that computes WIDTH-bit sums by sequencing a single 4-bit ripple adder slice over successive nibbles, LSB first. The carry is chained through a register between nibbles. The block sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It trades latency for area: one 4-bit slice replaces a WIDTH-bit adder.

## Interface
Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- sub  input  1  subtract select; present only with NIBSEQ_SUB_EN
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the top nibble

## Operation
- NIB = WIDTH/4. The nibble counter is max(1, clog2(NIB)) bits wide.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b and cin into the operand shift registers and the carry register, clear the counter, go to RUN.
  - RUN: each cycle, feed the low nibbles of the A and B registers plus the carry register into the 4-bit slice.
    - Shift the slice sum into sum[WIDTH-1:WIDTH-4] while the sum register shifts right by 4.
    - Shift the A and B registers right by 4.
    - Load the slice carry into the carry register.
    - After nibble NIB-1, go to DONE.
  - DONE: out_valid=1; sum and cout are held stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE, so operations never overlap. in_valid outside IDLE is ignored.
- cout equals the carry register once in DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, counter=0, carry register=0.
- Reset mid-operation (RUN or DONE): the operation is aborted and no result is presented. All state returns to reset values.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH, with cout as the carry out of bit WIDTH-1.

## Timing
- Operands accepted at the clock edge ending cycle T, where in_valid and in_ready are both 1.
- RUN occupies cycles T+1 through T+NIB.
- out_valid rises in cycle T+NIB+1, giving a latency of NIB+1 cycles.
- The handshake completes at the first edge where out_valid and out_ready are both 1. The block is in IDLE the next cycle.
- Maximum throughput is one operation per NIB+2 cycles.
- out_ready held low keeps the block in DONE indefinitely, with outputs unchanged.
- Outputs are registered. The only combinational path from inputs to outputs is none: in_ready depends on state only.

## Configuration
- NIBSEQ_SUB_EN defined:
  - The sub port exists.
  - With sub=1 at accept, the B register loads ~b and the carry register loads 1; cin is ignored.
  - The result is a - b mod 2^WIDTH, and cout=1 means no borrow.
  - With sub=0, behaviour is identical to add-only.
- NIBSEQ_SUB_EN undefined: the sub port and inversion logic are absent, and the block is add-only.

## Structure
- Shared package nibseq_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the slice width constant NIBBLE_W=4.
- One sub-module, nibble_add4: a combinational 4-bit ripple adder (a, b, cin to s, cout) built from per-bit sum/carry equations. It is instantiated once.
- The FSM, counter and shift registers live in the top module.

## Test plan
All scenarios use WIDTH=16, so NIB=4.
- Basic add: accept 0x1234 + 0x4321 with cin=0 at cycle T -> out_valid in cycle T+5, sum=0x5555, cout=0.
- Full carry ripple: 0xFFFF + 0x0001 with cin=0 -> sum=0x0000, cout=1. Also 0x0000 + 0x0000 with cin=1 -> sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum and cout stable, in_ready=0, new in_valid ignored. Raise out_ready -> next cycle in_ready=1.
- Reset mid-RUN: assert rst during cycle T+2 -> out_valid=0 and sum=0 immediately, in_ready=1 after release. A following 0x00FF + 0x0001 -> sum=0x0100.
- Back-to-back: in_valid and out_ready held at 1 -> accepts occur every 6 cycles, each result correct.
- With NIBSEQ_SUB_EN:
  - 0x0005 - 0x0007 with sub=1 -> sum=0xFFFE, cout=0.
  - 0x0007 - 0x0005 -> sum=0x0002, cout=1.
